// File: rtl/tx_pkg.sv
// Shared definitions for the tx character-channel frame sink.
//   TX_START / TX_STOP     : frame open / close markers on the 7-bit tx channel
//   TX_PRINT_LO / _HI      : printable character window used by the optional filter
//   tx_entry_t             : one FIFO entry, {last, data}
//   tx_state_e             : framing state (IDLE / FRAME)
package tx_pkg;

  localparam logic [6:0] TX_START    = 7'h00;
  localparam logic [6:0] TX_STOP     = 7'h7F;
  localparam logic [6:0] TX_PRINT_LO = 7'h20;
  localparam logic [6:0] TX_PRINT_HI = 7'h7E;

  typedef struct packed {
    logic       last;
    logic [6:0] data;
  } tx_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } tx_state_e;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= TX_PRINT_LO) && (c <= TX_PRINT_HI);
  endfunction

endpackage

// File: rtl/tx_frame_sink_if.sv
// Output stream of the frame sink: captured characters with end-of-frame marker.
//   out_data  : character at FIFO head (7'h00 on terminator entries)
//   out_last  : head entry is an end-of-frame terminator
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts head when out_valid && out_ready
// master = the sink (drives the stream), slave = the consumer.
interface tx_frame_sink_if;

  logic [6:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_last, output out_valid, input out_ready);
  modport slave  (input out_data, input out_last, input out_valid, output out_ready);

endinterface

// File: rtl/tx_fifo.sv
// Synchronous FIFO of tx_entry_t entries.
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, pop    : write / read requests; ignored when they cannot complete
//   din, dout    : write data / head entry (zero while empty)
//   full, empty  : occupancy flags
// Pointers carry one extra wrap bit: equal indices with differing wrap bits
// means full, fully equal pointers mean empty.
module tx_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  tx_entry_t din,
  output tx_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;
  tx_entry_t   mem [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

  // Storage is not reset; masking keeps the head at zero while empty.
  assign dout = empty ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/tx_frame_sink.sv
// Frame sink for the CPU's 7-bit tx character channel.
// Tracks 7'h00 (start) / 7'h7F (stop) markers, captures in-frame characters
// into a FIFO and presents them on a valid/ready stream with a terminator
// entry {last=1, data=0} at each frame end.
//   clk, reset_n : clock, asynchronous active-low reset
//   tx           : character channel, one event per rising edge
//   out_if       : output stream (master modport of tx_frame_sink_if)
//   in_frame     : registered framing state is FRAME
//   frames_done  : completed-frame count, wraps modulo 2^CNT_W
//   overflow     : sticky, a push was dropped on a full FIFO
// Optional build macro TX_PRINTABLE_FILTER_EN: when defined, in-frame
// characters outside 7'h20..7'h7E are discarded (terminators unaffected).
module tx_frame_sink
  import tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       tx,
  tx_frame_sink_if.master  out_if,
  output logic             in_frame,
  output logic [CNT_W-1:0] frames_done,
  output logic             overflow
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             overflow_q, overflow_d;

  logic      push_req, frame_end, pop_fire;
  logic      fifo_full, fifo_empty;
  tx_entry_t push_entry, head;

  assign pop_fire = !fifo_empty && out_if.out_ready;

  always_comb begin
    state_d    = state_q;
    push_req   = 1'b0;
    push_entry = '0;
    frame_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx == TX_START) state_d = FRAME;
      end
      FRAME: begin
        if (tx == TX_STOP) begin
          push_req   = 1'b1;
          push_entry = '{last: 1'b1, data: 7'h00};
          frame_end  = 1'b1;
          state_d    = IDLE;
        end else if (tx != TX_START) begin
`ifdef TX_PRINTABLE_FILTER_EN
          push_req   = is_printable(tx);
`else
          push_req   = 1'b1;
`endif
          push_entry = '{last: 1'b0, data: tx};
        end
      end
      default: state_d = IDLE;
    endcase

    // A dropped terminator still counts as a completed frame.
    frames_d   = frames_q + {{(CNT_W-1){1'b0}}, frame_end};
    overflow_d = overflow_q || (push_req && fifo_full && !pop_fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frames_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frames_q   <= frames_d;
      overflow_q <= overflow_d;
    end
  end

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop_fire),
    .din     (push_entry),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = head.data;
  assign out_if.out_last  = head.last;
  assign in_frame         = (state_q == FRAME);
  assign frames_done      = frames_q;
  assign overflow         = overflow_q;

endmodule

// File: doc/tx_frame_sink.md
Name: tx_frame_sink

Overview:
- Downstream consumer of the CPU's 7-bit `tx` character channel.
- Tracks the start/stop markers: 7'h00 opens a frame, 7'h7F closes it.
- Captures in-frame characters into a small FIFO and presents them on a valid/ready stream with an end-of-frame marker.
- Replaces ad-hoc bench-side printing with synthesizable capture, usable by a UART or a scoreboard.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk, input, 1: sole clock; all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tx, input, 7: CPU character channel, sampled every rising edge.
- out_data, output, 7: character at FIFO head; 7'h00 on terminator entries.
- out_last, output, 1: head entry is an end-of-frame terminator.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts head when out_valid && out_ready.
- in_frame, output, 1: state is FRAME.
- frames_done, output, CNT_W: count of completed frames; wraps modulo 2^CNT_W.
- overflow, output, 1: sticky; a push was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, out_valid=0, out_data=0, out_last=0, in_frame=0, frames_done=0, overflow=0.
- Each clock sample of tx is one event; a value held for N cycles yields N characters.
- IDLE:
  - tx==7'h00 -> FRAME; nothing pushed.
  - Any other value, including 7'h7F -> ignored.
- FRAME:
  - tx==7'h7F -> push terminator {last=1,data=0}; frames_done+1; -> IDLE.
  - tx==7'h00 -> ignored, stay FRAME (repeated start tolerated).
  - Any other value -> push {last=0,data=tx}.
- in_frame is the registered state; it rises the cycle after the 7'h00 sample.
- FIFO entry is 8 bits {last,data}. Write happens on the sampling edge.
- Latency: out_valid rises the cycle after the first push into an empty FIFO; out_data/out_last come straight from the head register.
- Pop on out_valid && out_ready. out_data and out_last must hold stable while out_valid && !out_ready.
- Push and pop in the same cycle:
  - Count unchanged; both pointers advance.
  - Allowed when full: the pop frees the slot.
  - When empty there is nothing to pop; the push proceeds.
- Full, push needed, no pop: entry dropped; overflow set. It stays set until reset_n.
  - A dropped terminator still increments frames_done and still returns to IDLE.
- frames_done wraps from 2^CNT_W-1 to 0 without flagging.
- Pointers are log2(DEPTH) bits plus one wrap bit; full = indices equal with wrap bits differing.
- Reset mid-frame: FIFO contents discarded, state IDLE; no terminator is emitted.

Optional Feature:
- Macro: TX_PRINTABLE_FILTER_EN.
- Defined: in-frame characters outside 7'h20..7'h7E are dropped. No push, no overflow effect. Terminators unaffected.
- Undefined: every in-frame value other than 7'h00/7'h7F is pushed.

Decomposition:
- Package tx_pkg:
  - TX_START=7'h00, TX_STOP=7'h7F.
  - Printable bounds 7'h20/7'h7E.
  - typedef tx_entry_t {logic last; logic [6:0] data;}.
  - enum tx_state_e {IDLE, FRAME}.
- Sub-module tx_fifo: synchronous FIFO of tx_entry_t, parameter DEPTH.
  - Ports: push, pop, full, empty, din, dout; async active-low reset.
  - The top module holds the FSM, counter and overflow logic.

Test Plan:
- tx sequence 00,'H','i',7F, out_ready=1 -> stream 'H'(last=0), 'i'(last=0), 00(last=1); frames_done=1; in_frame high 3 cycles.
- 'A',7F while IDLE, then 00,'B',7F -> only 'B' then terminator emitted; frames_done=1.
- DEPTH=4, out_ready=0, frame 00,'a','b','c','d','e',7F -> FIFO holds a,b,c,d; 'e' and terminator dropped; overflow=1; frames_done=1.
- FIFO full, out_ready=1, in-frame 'z' in the same cycle -> head popped and 'z' accepted; count stays 4; overflow stays 0.
- reset_n pulsed low mid-frame after 00,'x' (asynchronous, between edges) -> outputs zero immediately; 'y',7F afterwards ignored; frames_done=0.
- TX_PRINTABLE_FILTER_EN defined, frame 00,07,'Q',7F -> only 'Q' then terminator; undefined -> 07,'Q', terminator.
